video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised video timing and test-pattern generator for sound-only cores that need a valid, stable screen.
//  Generalises the fixed 640x480 dark-screen counter with these additions:
//   - all horizontal and vertical timings set by parameter; sync polarity set by parameter
//   - pixel clock-enable divider, frame counter and frame-start strobe
//   - run enable
//   - four test patterns, selected per frame
//  Sits between the system clock and the VGA_*/CE_PIXEL outputs of emu.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line (multiple of 8, >=8)
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame (>=1)
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    1 = hsync active high, 0 = active low
//  VS_POL    0    1 = vsync active high, 0 = active low
//  CE_DIV    2    system clocks per pixel (>=1)
//  COLOR_W   8    bits per colour channel
//  BG_LEVEL  8'h10  background grey level (truncated/zero-extended to COLOR_W)
// PORTS
//  clk          in   1        system clock (CLK_50M at top)
//  reset_n      in   1        synchronous reset, active low
//  en           in   1        run enable; low = generator held at reset state
//  pat_sel      in   2        test pattern select, sampled at frame start
//  ce_pix       out  1        pixel clock enable, 1-clk pulse every CE_DIV clks
//  hs           out  1        horizontal sync, polarity per HS_POL
//  vs           out  1        vertical sync, polarity per VS_POL
//  de           out  1        display enable (active region)
//  x_pos        out  16       active-region x of current output pixel
//  y_pos        out  16       active-region y of current output pixel
//  r/g/b        out  COLOR_W  pixel colour
//  frame_start  out  1        1-clk strobe at pixel (0,0)
//  frame_cnt    out  16       frames generated, wraps 16'hFFFF->0
// BEHAVIOUR
//  - Timing totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - Reset (reset_n=0 at a clk edge) or en=0 forces the following values on the next edge:
//    - divider=0; h=v=0; ce_pix=0
//    - hs=~HS_POL; vs=~VS_POL; de=0
//    - x_pos=y_pos=0; rgb=0; frame_start=0
//    - latched pattern=0
//    - frame_cnt=0 on reset only; en=0 holds frame_cnt at its current value.
//    - Reset has priority over en.
//  - Divider:
//    - counts 0..CE_DIV-1.
//    - ce_pix=1 for exactly the clk in which divider==CE_DIV-1.
//    - CE_DIV=1 gives ce_pix=1 on every clk.
//  - On each edge where ce_pix=1, outputs register decode(h,v), then h,v advance:
//    - h wraps H_TOTAL-1 -> 0, and v increments on that wrap.
//    - v wraps V_TOTAL-1 -> 0.
//    - Outputs are held between ce edges.
//    - Latency: pixel (h,v) is visible 1 clk after its ce edge, for CE_DIV clks.
//  - Decode:
//    - de = (h<H_ACTIVE && v<V_ACTIVE)
//    - hs active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
//    - vs active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
//    - x_pos=h and y_pos=v when de; otherwise x_pos/y_pos hold their last value.
//  - Frame start, at decode of (0,0):
//    - frame_start pulses for 1 clk.
//    - frame_cnt increments.
//    - pat_sel is latched; a mid-frame pat_sel change has no effect until the next frame start.
//  - Patterns (rgb = 0 whenever de=0):
//    - 0 solid: all channels BG_LEVEL.
//    - 1 bars: 8 bars of width H_ACTIVE/8, ordered W,Y,C,G,M,R,B,K with full-scale channels.
//      Bar index comes from a width counter reset at h=0; no divider is used.
//    - 2 grid: all-ones where x[4:0]==0 or y[4:0]==0; BG_LEVEL elsewhere.
//    - 3 ramp: all channels = x_pos[COLOR_W-1:0].
//  - Reset or en=0 mid-line/frame: the frame aborts immediately with no partial sync pulse stretching.
//    Restart begins at (0,0) with frame_start.
// TESTING (defaults unless stated; clk = 50 MHz)
//  1. Release reset, en=1:
//     - ce_pix high on every 2nd clk.
//     - hs low for exactly 192 clks starting at pixel 656.
//     - Line period = 1600 clks.
//  2. Run 2 frames:
//     - vs low for 2 lines starting at line 490.
//     - frame_start period = 840000 clks.
//     - frame_cnt 0->1->2.
//     - de high for 640x480 pixels per frame.
//  3. pat_sel 0->1 mid-frame:
//     - rgb stays 10/10/10 until the next frame_start.
//     - Then x=0..79 gives FF/FF/FF, x=560..639 gives 00/00/00, x=80 gives FF/FF/00.
//  4. Drop en at h=300, v=100, hold 10 clks, then raise:
//     - all outputs at reset values during the drop.
//     - frame_start 1 clk after the first ce.
//     - next hs edge 656 pixels later.
//     - frame_cnt unchanged by the drop.
//  5. reset_n=0 for 1 clk at frame_cnt=5:
//     - next clk all outputs at reset values, frame_cnt=0.
//  6. CE_DIV=1, H=8/1/1/1, V=2/1/1/1, force frame_cnt via 65536 frames:
//     - wraps to 0.
//     - ce_pix constantly high.
//     - pattern 3 ramp gives r=0..7 across the line.

Source files
------------

// File: rtl/video_timing_gen.sv
// Video timing and test-pattern generator: parametrised raster counters, pixel clock
// enable, sync/DE decode and four per-frame selectable test patterns.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CE_DIV   = 2,
  parameter int unsigned COLOR_W  = 8,
  parameter logic [7:0]  BG_LEVEL = 8'h10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [1:0]         pat_sel,
  output logic               ce_pix,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [15:0]        x_pos,
  output logic [15:0]        y_pos,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);
  localparam int unsigned DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [DW-1:0] DivMax = DW'(CE_DIV - 1);
  localparam logic [15:0] HLast   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] VLast   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] HAct    = 16'(H_ACTIVE);
  localparam logic [15:0] VAct    = 16'(V_ACTIVE);
  localparam logic [15:0] HsStart = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HsEnd   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VsStart = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VsEnd   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] BarLast = 16'(H_ACTIVE / 8 - 1);
  localparam logic [COLOR_W-1:0] Bg = COLOR_W'(BG_LEVEL);

  logic [DW-1:0]      div_q, div_d;
  logic               ce_q, ce_d;
  logic [15:0]        h_q, h_d, v_q, v_d;
  logic [15:0]        bar_w_q, bar_w_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  logic [1:0]         pat_q, pat_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [15:0]        x_q, x_d, y_q, y_d, fc_q, fc_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic               first, active;
  logic [1:0]         pat_cur;
  logic [COLOR_W-1:0] pr, pg, pb;

  // Pixel decode of the current (h, v); pattern for (0,0) comes straight from pat_sel
  always_comb begin
    first   = (h_q == '0) && (v_q == '0);
    active  = (h_q < HAct) && (v_q < VAct);
    pat_cur = first ? pat_sel : pat_q;
    pr = '0;
    pg = '0;
    pb = '0;
    case (pat_cur)
      2'd0: begin
        pr = Bg;
        pg = Bg;
        pb = Bg;
      end
      2'd1: begin
        pr = {COLOR_W{~bar_idx_q[1]}};
        pg = {COLOR_W{~bar_idx_q[2]}};
        pb = {COLOR_W{~bar_idx_q[0]}};
      end
      2'd2: begin
        if ((h_q[4:0] == 5'd0) || (v_q[4:0] == 5'd0)) begin
          pr = '1;
          pg = '1;
          pb = '1;
        end else begin
          pr = Bg;
          pg = Bg;
          pb = Bg;
        end
      end
      default: begin
        pr = h_q[COLOR_W-1:0];
        pg = h_q[COLOR_W-1:0];
        pb = h_q[COLOR_W-1:0];
      end
    endcase
  end

  always_comb begin
    div_d     = (div_q == DivMax) ? '0 : div_q + DW'(1);
    ce_d      = (div_d == DivMax);
    h_d       = h_q;
    v_d       = v_q;
    bar_w_d   = bar_w_q;
    bar_idx_d = bar_idx_q;
    pat_d     = pat_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    de_d      = de_q;
    x_d       = x_q;
    y_d       = y_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    fs_d      = 1'b0;
    fc_d      = fc_q;
    if (ce_q) begin
      h_d = (h_q == HLast) ? '0 : h_q + 16'd1;
      if (h_q == HLast) begin
        v_d = (v_q == VLast) ? '0 : v_q + 16'd1;
      end
      // Bar index tracks h with a width counter instead of dividing h
      if (h_q == HLast) begin
        bar_w_d   = '0;
        bar_idx_d = '0;
      end else if (bar_w_q == BarLast) begin
        bar_w_d   = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_w_d = bar_w_q + 16'd1;
      end
      hs_d = ((h_q >= HsStart) && (h_q < HsEnd)) ? HS_POL : ~HS_POL;
      vs_d = ((v_q >= VsStart) && (v_q < VsEnd)) ? VS_POL : ~VS_POL;
      de_d = active;
      if (active) begin
        x_d = h_q;
        y_d = v_q;
      end
      r_d  = active ? pr : '0;
      g_d  = active ? pg : '0;
      b_d  = active ? pb : '0;
      fs_d = first;
      if (first) begin
        fc_d  = fc_q + 16'd1;
        pat_d = pat_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      div_q     <= '0;
      ce_q      <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      bar_w_q   <= '0;
      bar_idx_q <= '0;
      pat_q     <= '0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      fs_q      <= 1'b0;
      if (!reset_n) begin
        fc_q <= '0;
      end
    end else begin
      div_q     <= div_d;
      ce_q      <= ce_d;
      h_q       <= h_d;
      v_q       <= v_d;
      bar_w_q   <= bar_w_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      x_q       <= x_d;
      y_q       <= y_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      fs_q      <= fs_d;
      fc_q      <= fc_d;
    end
  end

  assign ce_pix      = ce_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a reduced raster (24x8 total, 16x4 active, CE_DIV=2) checked
// through an expected-pixel queue, plus a tiny CE_DIV=1 instance for ramp/polarity.
module tb_video_timing_gen;
  localparam int HT = 24;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset_n, en;
  logic [1:0]  pat_sel;
  logic        ce_pix, hs, vs, de, frame_start;
  logic [15:0] x_pos, y_pos, frame_cnt;
  logic [7:0]  r, g, b;

  logic        s_rst_n, s_en;
  logic [1:0]  s_pat;
  logic        s_ce, s_hs, s_vs, s_de, s_fs;
  logic [15:0] s_x, s_y, s_fc;
  logic [7:0]  s_r, s_g, s_b;

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CE_DIV(2), .COLOR_W(8), .BG_LEVEL(8'h10)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .pat_sel(pat_sel), .ce_pix(ce_pix),
    .hs(hs), .vs(vs), .de(de), .x_pos(x_pos), .y_pos(y_pos), .r(r), .g(g), .b(b),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CE_DIV(1), .COLOR_W(8), .BG_LEVEL(8'h10)
  ) u_small (
    .clk(clk), .reset_n(s_rst_n), .en(s_en), .pat_sel(s_pat), .ce_pix(s_ce),
    .hs(s_hs), .vs(s_vs), .de(s_de), .x_pos(s_x), .y_pos(s_y), .r(s_r), .g(s_g), .b(s_b),
    .frame_start(s_fs), .frame_cnt(s_fc)
  );

  typedef struct packed {
    logic [15:0] h, v;
    logic        fs, de, hs, vs;
    logic [15:0] x, y, fc;
    logic [7:0]  r, g, b;
  } px_t;

  px_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int h, v, fs, de, hse, vse, x, y, fc, rr, gg, bb);
    px_t e;
    e.h  = 16'(h);
    e.v  = 16'(v);
    e.fs = 1'(fs);
    e.de = 1'(de);
    e.hs = 1'(hse);
    e.vs = 1'(vse);
    e.x  = 16'(x);
    e.y  = 16'(y);
    e.fc = 16'(fc);
    e.r  = 8'(rr);
    e.g  = 8'(gg);
    e.b  = 8'(bb);
    exp_q.push_back(e);
  endtask

  // sel 0 = hs, 1 = frame_start; counts negedges until the signal reaches lvl
  task automatic wait_sig(input int sel, input logic lvl, output int n);
    logic s;
    n = 0;
    forever begin
      s = (sel == 0) ? hs : frame_start;
      if (s === lvl || n >= 2000) break;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag, input logic [15:0] fc);
    chk({tag, ".ce"}, 32'(ce_pix), 32'd0);
    chk({tag, ".hs"}, 32'(hs), 32'd1);
    chk({tag, ".vs"}, 32'(vs), 32'd1);
    chk({tag, ".de"}, 32'(de), 32'd0);
    chk({tag, ".x"}, 32'(x_pos), 32'd0);
    chk({tag, ".y"}, 32'(y_pos), 32'd0);
    chk({tag, ".rgb"}, {8'd0, r, g, b}, 32'd0);
    chk({tag, ".fs"}, 32'(frame_start), 32'd0);
    chk({tag, ".fc"}, 32'(frame_cnt), 32'(fc));
  endtask

  // Monitor: a pixel is presented on the clock after a ce_pix cycle; position is
  // counted from the most recent presented frame_start.
  bit  mon_ce_prev = 1'b0;
  bit  mon_synced = 1'b0;
  int  mon_idx = 0;
  px_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_ce_prev) begin
        if (frame_start) begin
          mon_synced = 1'b1;
          mon_idx = 0;
        end else begin
          mon_idx++;
        end
        if (mon_synced && exp_q.size() > 0 && int'(exp_q[0].h) == mon_idx % HT
            && int'(exp_q[0].v) == mon_idx / HT) begin
          mon_e = exp_q.pop_front();
          chk($sformatf("fs@%0d,%0d", mon_e.h, mon_e.v), 32'(frame_start), 32'(mon_e.fs));
          chk($sformatf("de@%0d,%0d", mon_e.h, mon_e.v), 32'(de), 32'(mon_e.de));
          chk($sformatf("hs@%0d,%0d", mon_e.h, mon_e.v), 32'(hs), 32'(mon_e.hs));
          chk($sformatf("vs@%0d,%0d", mon_e.h, mon_e.v), 32'(vs), 32'(mon_e.vs));
          chk($sformatf("x@%0d,%0d", mon_e.h, mon_e.v), 32'(x_pos), 32'(mon_e.x));
          chk($sformatf("y@%0d,%0d", mon_e.h, mon_e.v), 32'(y_pos), 32'(mon_e.y));
          chk($sformatf("fc@%0d,%0d", mon_e.h, mon_e.v), 32'(frame_cnt), 32'(mon_e.fc));
          chk($sformatf("rgb@%0d,%0d", mon_e.h, mon_e.v), {8'd0, r, g, b},
              {8'd0, mon_e.r, mon_e.g, mon_e.b});
        end
      end
      mon_ce_prev = ce_pix;
    end
  end

  initial begin
    #(200000 * 20);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n1, n2, cnt;
    reset_n = 1'b0;
    en      = 1'b1;
    pat_sel = 2'd0;
    s_rst_n = 1'b0;
    s_en    = 1'b1;
    s_pat   = 2'd3;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst", 16'd0);

    //   h   v fs de hs vs  x  y fc   r     g     b
    // Frame 0: solid background
    push( 0, 0, 1, 1, 1, 1,  0, 0, 1, 'h10, 'h10, 'h10);
    push(15, 0, 0, 1, 1, 1, 15, 0, 1, 'h10, 'h10, 'h10);
    push(16, 0, 0, 0, 1, 1, 15, 0, 1, 0, 0, 0);
    push(18, 0, 0, 0, 0, 1, 15, 0, 1, 0, 0, 0);
    push(20, 0, 0, 0, 0, 1, 15, 0, 1, 0, 0, 0);
    push(21, 0, 0, 0, 1, 1, 15, 0, 1, 0, 0, 0);
    push( 3, 2, 0, 1, 1, 1,  3, 2, 1, 'h10, 'h10, 'h10);
    push( 5, 3, 0, 1, 1, 1,  5, 3, 1, 'h10, 'h10, 'h10);
    push( 0, 4, 0, 0, 1, 1, 15, 3, 1, 0, 0, 0);
    push( 0, 5, 0, 0, 1, 0, 15, 3, 1, 0, 0, 0);
    push(23, 6, 0, 0, 1, 0, 15, 3, 1, 0, 0, 0);
    push( 0, 7, 0, 0, 1, 1, 15, 3, 1, 0, 0, 0);
    // Frame 1: colour bars, two pixels wide
    push( 0, 0, 1, 1, 1, 1,  0, 0, 2, 'hff, 'hff, 'hff);
    push( 1, 0, 0, 1, 1, 1,  1, 0, 2, 'hff, 'hff, 'hff);
    push( 2, 0, 0, 1, 1, 1,  2, 0, 2, 'hff, 'hff, 0);
    push( 4, 1, 0, 1, 1, 1,  4, 1, 2, 0, 'hff, 'hff);
    push( 6, 2, 0, 1, 1, 1,  6, 2, 2, 0, 'hff, 0);
    push( 8, 2, 0, 1, 1, 1,  8, 2, 2, 'hff, 0, 'hff);
    push(10, 3, 0, 1, 1, 1, 10, 3, 2, 'hff, 0, 0);
    push(12, 3, 0, 1, 1, 1, 12, 3, 2, 0, 0, 'hff);
    push(15, 3, 0, 1, 1, 1, 15, 3, 2, 0, 0, 0);
    push(16, 3, 0, 0, 1, 1, 15, 3, 2, 0, 0, 0);
    // Frame 2: grid
    push( 0, 0, 1, 1, 1, 1,  0, 0, 3, 'hff, 'hff, 'hff);
    push( 1, 0, 0, 1, 1, 1,  1, 0, 3, 'hff, 'hff, 'hff);
    push( 1, 1, 0, 1, 1, 1,  1, 1, 3, 'h10, 'h10, 'h10);
    push( 0, 2, 0, 1, 1, 1,  0, 2, 3, 'hff, 'hff, 'hff);
    push( 5, 3, 0, 1, 1, 1,  5, 3, 3, 'h10, 'h10, 'h10);
    // Frame 3: ramp
    push( 0, 0, 1, 1, 1, 1,  0, 0, 4, 0, 0, 0);
    push( 7, 1, 0, 1, 1, 1,  7, 1, 4, 7, 7, 7);
    push(15, 2, 0, 1, 1, 1, 15, 2, 4, 'h0f, 'h0f, 'h0f);

    reset_n = 1'b1;
    @(negedge clk); chk("ce.0", 32'(ce_pix), 32'd1);
    @(negedge clk); chk("ce.1", 32'(ce_pix), 32'd0);
    @(negedge clk); chk("ce.2", 32'(ce_pix), 32'd1);
    @(negedge clk); chk("ce.3", 32'(ce_pix), 32'd0);
    pat_sel = 2'd1;

    wait_sig(0, 1'b0, n1);
    wait_sig(0, 1'b1, n1);
    chk("hs_low_clks", 32'(n1), 32'd6);
    wait_sig(0, 1'b0, n2);
    chk("line_clks", 32'(n1 + n2), 32'd48);

    for (int p = 2; p <= 3; p++) begin
      wait_sig(1, 1'b1, n1);
      repeat (60) @(negedge clk);
      pat_sel = 2'(p);
    end
    wait_sig(1, 1'b1, n1);
    wait_sig(1, 1'b0, n1);
    wait_sig(1, 1'b1, n2);
    chk("frame_clks", 32'(n1 + n2), 32'd384);
    chk("fc_frame4", 32'(frame_cnt), 32'd5);
    drain("drain_patterns");

    // Enable drop mid-frame
    repeat (50) @(negedge clk);
    en = 1'b0;
    pat_sel = 2'd0;
    @(negedge clk);
    chk_reset_outputs("endrop", 16'd5);
    repeat (9) @(negedge clk);
    chk("endrop.ce_end", 32'(ce_pix), 32'd0);
    chk("endrop.fc_end", 32'(frame_cnt), 32'd5);
    push( 0, 0, 1, 1, 1, 1,  0, 0, 6, 'h10, 'h10, 'h10);
    push(18, 0, 0, 0, 0, 1, 15, 0, 6, 0, 0, 0);
    en = 1'b1;
    @(negedge clk);
    chk("restart.ce", 32'(ce_pix), 32'd1);
    chk("restart.fs0", 32'(frame_start), 32'd0);
    @(negedge clk);
    chk("restart.fs1", 32'(frame_start), 32'd1);
    wait_sig(0, 1'b0, n1);
    chk("restart.hs_clks", 32'(n1), 32'd36);
    drain("drain_restart");

    // One-clock reset pulse
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rstpulse", 16'd0);
    reset_n = 1'b1;
    push(0, 0, 1, 1, 1, 1, 0, 0, 1, 'h10, 'h10, 'h10);
    drain("drain_rstpulse");

    // CE_DIV=1 instance: constant ce, active-high syncs, ramp 0..7
    chk("s.rst_hs", 32'(s_hs), 32'd0);
    chk("s.rst_vs", 32'(s_vs), 32'd0);
    chk("s.rst_ce", 32'(s_ce), 32'd0);
    s_rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (s_ce) cnt++;
    end
    chk("s.ce_high", 32'(cnt), 32'd30);
    n1 = 0;
    while (!s_fs && n1 < 200) begin
      @(negedge clk);
      n1++;
    end
    chk("s.fs", 32'(s_fs), 32'd1);
    chk("s.fc", 32'(s_fc), 32'd2);
    chk("s.y", 32'(s_y), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("s.ramp%0d", i), {8'd0, s_r, s_g, s_b}, {8'd0, 8'(i), 8'(i), 8'(i)});
      chk($sformatf("s.x%0d", i), 32'(s_x), 32'(i));
    end
    @(negedge clk);
    chk("s.de_off", 32'(s_de), 32'd0);
    @(negedge clk);
    chk("s.hs_on", 32'(s_hs), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
